// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the hazard/forwarding controller.
// Stage indices, FSM states, tracker record and select encoding.
package hazard_pkg;

  localparam int ST_EX  = 0;
  localparam int ST_MEM = 1;
  localparam int ST_WB  = 2;

  localparam int SEL_RF = 0;

  // Widest register index a tracker record can hold.
  localparam int REG_AW_MAX = 8;

  typedef enum logic {
    RUN,
    MEM_WAIT
  } fsm_e;

  typedef struct packed {
    logic                  v;
    logic                  wen;
    logic                  ld;
    logic [REG_AW_MAX-1:0] dst;
  } stage_t;

endpackage

// File: rtl/fwd_match.sv
// fwd_match: priority matcher for one source operand.
// The youngest in-flight writer of the register wins.
module fwd_match
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SEL_W = 2
) (
  input  stage_t [DEPTH-1:0] i_stg,
  input  logic [REG_AW_MAX-1:0] i_src,
  input  logic               i_used,
  output logic [SEL_W-1:0]   o_sel,
  output logic               o_hit_load0
);

  logic [SEL_W-1:0] w_sel;

  // Scan oldest to youngest so the lowest stage index is kept.
  always_comb begin
    w_sel = SEL_W'(SEL_RF);
    if (i_used && (i_src != '0)) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (i_stg[k].v && i_stg[k].wen &&
            (i_stg[k].dst == i_src)) begin
          w_sel = SEL_W'(k + 1);
        end
      end
    end
  end

  assign o_sel       = w_sel;
  assign o_hit_load0 = (w_sel == SEL_W'(ST_EX + 1)) &&
                       i_stg[ST_EX].ld;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: in-flight writer tracker, forward selects, stalls.
// Define HAZARD_PERF_CNT_EN to add saturating event counters.
module hazard_fwd_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int SEL_W   = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         id_dst,
  input  logic                      id_wen,
  input  logic                      id_is_load,
  input  logic                      mem_ready,
  input  logic                      flush,
  output logic                      stall,
  output logic                      hold_pipe,
  output logic                      issue,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]               cnt_load_use,
  output logic [31:0]               cnt_mem_wait,
  output logic [31:0]               cnt_fwd
`endif
);

  if (DEPTH < ST_WB || REG_AW > REG_AW_MAX) begin : g_bad_cfg
    $error("hazard_fwd_ctrl: DEPTH >= 2 and REG_AW <= 8");
  end

  stage_t [DEPTH-1:0] r_stg;
  fsm_e               r_state;
  fsm_e               w_state_nxt;
  stage_t             w_in;
  logic [NUM_SRC-1:0] w_hit0;
  logic               w_mem_wait;
  logic               w_load_use;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_match #(
      .DEPTH (DEPTH),
      .SEL_W (SEL_W)
    ) u_match (
      .i_stg       (r_stg),
      .i_src       (REG_AW_MAX'(id_src[s*REG_AW +: REG_AW])),
      .i_used      (id_src_used[s]),
      .o_sel       (fwd_sel[s*SEL_W +: SEL_W]),
      .o_hit_load0 (w_hit0[s])
    );
  end

  assign w_mem_wait = r_stg[ST_MEM].v && r_stg[ST_MEM].ld &&
                      !mem_ready;
  assign w_load_use = |w_hit0;

  assign hold_pipe = w_mem_wait;
  assign stall     = w_mem_wait || w_load_use;
  assign issue     = id_valid && !stall && !flush;

  // Entry for stage 0: the issuing instruction or a bubble.
  always_comb begin
    w_in = '0;
    if (issue) begin
      w_in.v   = 1'b1;
      w_in.wen = id_wen;
      w_in.ld  = id_is_load;
      w_in.dst = REG_AW_MAX'(id_dst);
    end
  end

  // Tag pipeline: shift on advance, freeze while memory waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg <= '0;
    end else if (!w_mem_wait) begin
      r_stg <= {r_stg[DEPTH-2:0], w_in};
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: wait while the stage-1 load lacks data.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN:      if (w_mem_wait) w_state_nxt = MEM_WAIT;
      MEM_WAIT: if (mem_ready)  w_state_nxt = RUN;
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_cnt_lu;
  logic [31:0] r_cnt_mw;
  logic [31:0] r_cnt_fwd;
  logic        w_fwd_ev;

  assign w_fwd_ev = issue && (fwd_sel != '0);

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_lu  <= '0;
      r_cnt_mw  <= '0;
      r_cnt_fwd <= '0;
    end else begin
      if (w_load_use && (r_cnt_lu != '1))
        r_cnt_lu <= r_cnt_lu + 32'd1;
      if (w_mem_wait && (r_cnt_mw != '1))
        r_cnt_mw <= r_cnt_mw + 32'd1;
      if (w_fwd_ev && (r_cnt_fwd != '1))
        r_cnt_fwd <= r_cnt_fwd + 32'd1;
    end
  end

  assign cnt_load_use = r_cnt_lu;
  assign cnt_mem_wait = r_cnt_mw;
  assign cnt_fwd      = r_cnt_fwd;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: directed vector table plus random run
// against a queue-based model of in-flight instructions.
module tb_hazard_fwd_ctrl;

  localparam int REG_AW  = 5;
  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 3;
  localparam int SEL_W   = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic id_valid = 1'b0;
  logic [NUM_SRC*REG_AW-1:0] id_src = '0;
  logic [NUM_SRC-1:0] id_src_used = '0;
  logic [REG_AW-1:0] id_dst = '0;
  logic id_wen = 1'b0;
  logic id_is_load = 1'b0;
  logic mem_ready = 1'b1;
  logic flush = 1'b0;
  logic stall, hold_pipe, issue;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(
    .REG_AW  (REG_AW),
    .NUM_SRC (NUM_SRC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_src      (id_src),
    .id_src_used (id_src_used),
    .id_dst      (id_dst),
    .id_wen      (id_wen),
    .id_is_load  (id_is_load),
    .mem_ready   (mem_ready),
    .flush       (flush),
    .stall       (stall),
    .hold_pipe   (hold_pipe),
    .issue       (issue),
    .fwd_sel     (fwd_sel)
  );

  typedef struct {
    bit v; bit wen; bit ld; int dst;
  } ent_t;

  typedef struct {
    bit v; int s0; int s1; bit [1:0] u; int d;
    bit w; bit l; bit mr; bit fl;
    bit st; bit hp; bit is; int f0; int f1;
  } vec_t;

  // q[0] is the youngest in-flight instruction (EX).
  ent_t q[$];
  vec_t tbl[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t V(bit v, int s0, int s1, bit [1:0] u,
                             int d, bit w, bit l, bit mr, bit fl,
                             bit st, bit hp, bit is, int f0, int f1);
    vec_t r;
    r.v = v; r.s0 = s0; r.s1 = s1; r.u = u; r.d = d;
    r.w = w; r.l = l; r.mr = mr; r.fl = fl;
    r.st = st; r.hp = hp; r.is = is; r.f0 = f0; r.f1 = f1;
    return r;
  endfunction

  function automatic void mclear();
    ent_t b;
    b = '{v: 0, wen: 0, ld: 0, dst: 0};
    q.delete();
    for (int k = 0; k < DEPTH; k++) q.push_back(b);
  endfunction

  function automatic void mstep(input vec_t c, output bit st,
                                output bit hp, output bit is,
                                output int f0, output int f1);
    int src[2];
    int f[2];
    bit lu, mw;
    ent_t e;
    src[0] = c.s0;
    src[1] = c.s1;
    lu = 0;
    for (int s = 0; s < 2; s++) begin
      f[s] = 0;
      if (c.u[s] && src[s] != 0)
        for (int k = 0; k < DEPTH; k++)
          if (f[s] == 0 && q[k].v && q[k].wen && q[k].dst == src[s])
            f[s] = k + 1;
      if (f[s] == 1 && q[0].ld) lu = 1;
    end
    mw = q[1].v && q[1].ld && !c.mr;
    st = mw || lu;
    hp = mw;
    is = c.v && !st && !c.fl;
    f0 = f[0];
    f1 = f[1];
    if (!mw) begin
      e = '{v: 0, wen: 0, ld: 0, dst: 0};
      if (is) e = '{v: 1, wen: c.w, ld: c.l, dst: c.d};
      void'(q.pop_back());
      q.push_front(e);
    end
  endfunction

  task automatic step(input string nm, input vec_t c,
                      input bit use_tbl);
    bit st, hp, is;
    int f0, f1;
    @(negedge clk);
    id_valid    = c.v;
    id_src      = {REG_AW'(c.s1), REG_AW'(c.s0)};
    id_src_used = c.u;
    id_dst      = REG_AW'(c.d);
    id_wen      = c.w;
    id_is_load  = c.l;
    mem_ready   = c.mr;
    flush       = c.fl;
    #1;
    mstep(c, st, hp, is, f0, f1);
    if (use_tbl) begin
      st = c.st; hp = c.hp; is = c.is; f0 = c.f0; f1 = c.f1;
    end
    n_vec++;
    if (stall !== st || hold_pipe !== hp || issue !== is ||
        fwd_sel[1:0] !== SEL_W'(f0) ||
        fwd_sel[3:2] !== SEL_W'(f1)) begin
      n_bad++;
      $display("FAIL %s: got st=%0b hp=%0b is=%0b sel=%0d,%0d exp st=%0b hp=%0b is=%0b sel=%0d,%0d",
               nm, stall, hold_pipe, issue, fwd_sel[1:0],
               fwd_sel[3:2], st, hp, is, f0, f1);
    end
  endtask

  initial begin
    vec_t c;
    string nm;
    mclear();
    // reset state
    tbl.push_back(V(0,0,0,0, 0,0,0,1,0, 0,0,0,0,0));
    // back-to-back ALU
    tbl.push_back(V(1,1,2,3, 3,1,0,1,0, 0,0,1,0,0));
    tbl.push_back(V(1,3,4,3, 5,1,0,1,0, 0,0,1,1,0));
    // distance 2/3/4
    tbl.push_back(V(1,0,0,0, 3,1,0,1,0, 0,0,1,0,0));
    tbl.push_back(V(1,0,0,0, 9,1,0,1,0, 0,0,1,0,0));
    tbl.push_back(V(1,3,0,1, 0,0,0,1,0, 0,0,1,2,0));
    tbl.push_back(V(1,0,3,2, 0,0,0,1,0, 0,0,1,0,3));
    tbl.push_back(V(1,3,3,3, 0,0,0,1,0, 0,0,1,0,0));
    // double writer r7
    tbl.push_back(V(1,0,0,0, 7,1,0,1,0, 0,0,1,0,0));
    tbl.push_back(V(1,0,0,0, 7,1,0,1,0, 0,0,1,0,0));
    tbl.push_back(V(1,7,7,3, 0,0,0,1,0, 0,0,1,1,1));
    // r0 never forwards
    tbl.push_back(V(1,0,0,0, 0,1,0,1,0, 0,0,1,0,0));
    tbl.push_back(V(1,0,0,3, 0,0,0,1,0, 0,0,1,0,0));
    // load-use, 1-cycle memory
    tbl.push_back(V(1,1,0,1, 2,1,1,1,0, 0,0,1,0,0));
    tbl.push_back(V(1,2,2,3, 4,1,0,1,0, 1,0,0,1,1));
    tbl.push_back(V(1,2,2,3, 4,1,0,1,0, 0,0,1,2,2));
    // multi-cycle load, 3 wait cycles
    tbl.push_back(V(1,0,0,0, 6,1,1,1,0, 0,0,1,0,0));
    tbl.push_back(V(1,0,0,0, 8,1,0,1,0, 0,0,1,0,0));
    tbl.push_back(V(1,8,0,1, 9,1,0,0,0, 1,1,0,1,0));
    tbl.push_back(V(1,8,0,1, 9,1,0,0,0, 1,1,0,1,0));
    tbl.push_back(V(1,8,0,1, 9,1,0,0,0, 1,1,0,1,0));
    tbl.push_back(V(1,8,0,1, 9,1,0,1,0, 0,0,1,1,0));
    // flush during load-use, then plain flush
    tbl.push_back(V(1,0,0,0, 2,1,1,1,0, 0,0,1,0,0));
    tbl.push_back(V(1,2,0,1, 0,0,0,1,1, 1,0,0,1,0));
    tbl.push_back(V(1,2,0,1, 0,0,0,1,0, 0,0,1,2,0));
    tbl.push_back(V(1,0,0,0, 11,1,0,1,1, 0,0,0,0,0));
    tbl.push_back(V(1,11,0,1, 0,0,0,1,0, 0,0,1,0,0));
    // load-use coincident with memory wait
    tbl.push_back(V(1,0,0,0, 5,1,1,1,0, 0,0,1,0,0));
    tbl.push_back(V(1,0,0,0, 6,1,1,1,0, 0,0,1,0,0));
    tbl.push_back(V(1,6,0,1, 0,0,0,0,0, 1,1,0,1,0));
    tbl.push_back(V(1,6,0,1, 0,0,0,1,0, 1,0,0,1,0));
    tbl.push_back(V(1,6,0,1, 0,0,0,1,0, 0,0,1,2,0));
    // enter MEM_WAIT before a reset pulse
    tbl.push_back(V(1,0,0,0, 12,1,1,1,0, 0,0,1,0,0));
    tbl.push_back(V(1,0,0,0, 13,1,0,1,0, 0,0,1,0,0));
    tbl.push_back(V(0,0,0,0, 0,0,0,0,0, 1,1,0,0,0));

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      nm = $sformatf("tbl%0d", i);
      step(nm, tbl[i], 1'b1);
    end

    // asynchronous reset while held in MEM_WAIT
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if (stall !== 1'b0 || hold_pipe !== 1'b0 || issue !== 1'b0 ||
        fwd_sel !== '0) begin
      n_bad++;
      $display("FAIL async_rst: got st=%0b hp=%0b is=%0b sel=%0h exp all 0",
               stall, hold_pipe, issue, fwd_sel);
    end
    mclear();
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst_idle", V(0,12,13,3, 0,0,0,0,0, 0,0,0,0,0), 1'b1);
    step("post_rst_read", V(1,12,13,3, 0,0,0,0,0, 0,0,1,0,0), 1'b1);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      c = V($urandom_range(9) != 0, $urandom_range(7),
            $urandom_range(7), 2'($urandom_range(3)),
            $urandom_range(7), $urandom_range(3) != 0,
            $urandom_range(2) == 0, $urandom_range(9) < 6,
            $urandom_range(9) == 0, 0, 0, 0, 0, 0);
      nm = $sformatf("rnd%0d", i);
      step(nm, c, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
